// File: rtl/pe_layer_seq.sv
// Layer sequencer for the PE array: weight load, compute, PPU drain, bank swap.
// Optional watchdog enabled by defining PE_SEQ_WATCHDOG_EN.
module pe_layer_seq #(
   parameter int KP_W = 4,
   parameter int C_W  = 4
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [KP_W-1:0] num_kgroup,
   input  logic [C_W-1:0]  num_channel,
   output logic            weight_load_req,
   input  logic            weight_load_done,
   output logic            compute_start,
   input  logic            compute_done,
   output logic            ppu_start,
   input  logic            PPU_finish_en,
   output logic            bank_sel,
   output logic [KP_W-1:0] kgroup_idx,
   output logic [C_W-1:0]  channel_idx,
   output logic            busy,
   output logic            layer_done,
   output logic            timeout
);

   typedef enum logic [2:0] {
      IDLE, LOAD_W, COMPUTE, DRAIN, SWAP
   } state_t;

   state_t          state_q, state_d;
   logic [KP_W-1:0] nk_q, nk_d, kg_d, kg_last;
   logic [C_W-1:0]  nc_q, nc_d, ch_d, ch_last;

   assign kg_last = nk_q - 1'b1;
   assign ch_last = nc_q - 1'b1;

`ifdef PE_SEQ_WATCHDOG_EN
   logic [9:0] wd_q;
   logic       in_wait;
   assign in_wait = (state_q == LOAD_W) || (state_q == COMPUTE) ||
                    (state_q == DRAIN);
`endif

   always_comb begin
      state_d = state_q;
      nk_d    = nk_q;
      nc_d    = nc_q;
      kg_d    = kgroup_idx;
      ch_d    = channel_idx;
      unique case (state_q)
         IDLE: begin
            if (start && num_kgroup != '0 && num_channel != '0) begin
               state_d = LOAD_W;
               nk_d    = num_kgroup;
               nc_d    = num_channel;
               kg_d    = '0;
               ch_d    = '0;
            end
         end
         LOAD_W: begin
            if (weight_load_done) state_d = COMPUTE;
         end
         COMPUTE: begin
            if (compute_done) begin
               if (channel_idx == ch_last) begin
                  state_d = DRAIN;
               end else begin
                  ch_d    = channel_idx + 1'b1;
                  state_d = LOAD_W;
               end
            end
         end
         DRAIN: begin
            if (PPU_finish_en) begin
               if (kgroup_idx == kg_last) begin
                  state_d = SWAP;
               end else begin
                  kg_d    = kgroup_idx + 1'b1;
                  ch_d    = '0;
                  state_d = LOAD_W;
               end
            end
         end
         SWAP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
`ifdef PE_SEQ_WATCHDOG_EN
      // Expiry wins over any handshake arriving in the same cycle
      if (in_wait && wd_q == 10'd1023) state_d = IDLE;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= IDLE;
         nk_q            <= '0;
         nc_q            <= '0;
         kgroup_idx      <= '0;
         channel_idx     <= '0;
         weight_load_req <= 1'b0;
         compute_start   <= 1'b0;
         ppu_start       <= 1'b0;
         busy            <= 1'b0;
         layer_done      <= 1'b0;
         bank_sel        <= 1'b0;
      end else begin
         state_q         <= state_d;
         nk_q            <= nk_d;
         nc_q            <= nc_d;
         kgroup_idx      <= kg_d;
         channel_idx     <= ch_d;
         weight_load_req <= (state_d == LOAD_W);
         compute_start   <= (state_d == COMPUTE) && (state_q != COMPUTE);
         ppu_start       <= (state_d == DRAIN) && (state_q != DRAIN);
         busy            <= (state_d != IDLE);
         layer_done      <= (state_d == SWAP);
         if (state_d == SWAP) bank_sel <= ~bank_sel;
      end
   end

`ifdef PE_SEQ_WATCHDOG_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         wd_q    <= '0;
         timeout <= 1'b0;
      end else begin
         if (state_d != state_q) wd_q <= '0;
         else if (in_wait)       wd_q <= wd_q + 1'b1;
         timeout <= in_wait && (state_d == state_q) && (wd_q == 10'd1022);
      end
   end
`else
   assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_pe_layer_seq.sv
// Directed self-checking bench for pe_layer_seq.
module tb_pe_layer_seq;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [3:0] num_kgroup;
   logic [3:0] num_channel;
   logic       weight_load_req;
   logic       weight_load_done;
   logic       compute_start;
   logic       compute_done;
   logic       ppu_start;
   logic       PPU_finish_en;
   logic       bank_sel;
   logic [3:0] kgroup_idx;
   logic [3:0] channel_idx;
   logic       busy;
   logic       layer_done;
   logic       timeout;

   int errors = 0;
   int checks = 0;
   int n_cs = 0, n_ps = 0, n_ld = 0, n_to = 0;

   pe_layer_seq #(.KP_W(4), .C_W(4)) dut (
      .clk              (clk),
      .rst              (rst),
      .start            (start),
      .num_kgroup       (num_kgroup),
      .num_channel      (num_channel),
      .weight_load_req  (weight_load_req),
      .weight_load_done (weight_load_done),
      .compute_start    (compute_start),
      .compute_done     (compute_done),
      .ppu_start        (ppu_start),
      .PPU_finish_en    (PPU_finish_en),
      .bank_sel         (bank_sel),
      .kgroup_idx       (kgroup_idx),
      .channel_idx      (channel_idx),
      .busy             (busy),
      .layer_done       (layer_done),
      .timeout          (timeout)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (compute_start === 1'b1) n_cs <= n_cs + 1;
      if (ppu_start === 1'b1)     n_ps <= n_ps + 1;
      if (layer_done === 1'b1)    n_ld <= n_ld + 1;
      if (timeout === 1'b1)       n_to <= n_to + 1;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic logic sig_val(input int s);
      case (s)
         0:       return weight_load_req;
         1:       return compute_start;
         default: return ppu_start;
      endcase
   endfunction

   task automatic wait_sig(input int s, input string tag);
      int n = 0;
      while (sig_val(s) !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      chk(tag, int'(sig_val(s)), 1);
   endtask

   task automatic hs_load(input int dly);
      wait_sig(0, "wait_wlr");
      repeat (dly) tick();
      weight_load_done = 1'b1;
      tick();
      weight_load_done = 1'b0;
   endtask

   task automatic hs_comp(input int dly);
      wait_sig(1, "wait_cs");
      repeat (dly) tick();
      compute_done = 1'b1;
      tick();
      compute_done = 1'b0;
   endtask

   task automatic hs_drain(input int dly);
      wait_sig(2, "wait_ps");
      repeat (dly) tick();
      PPU_finish_en = 1'b1;
      tick();
      PPU_finish_en = 1'b0;
   endtask

   task automatic run_layer(input int nk, input int nc, input int dly);
      num_kgroup  = 4'(nk);
      num_channel = 4'(nc);
      start = 1'b1;
      tick();
      chk("start_busy", int'(busy), 1);
      // Counts changed and start held while busy: both must be ignored
      num_kgroup  = 4'd15;
      num_channel = 4'd15;
      tick();
      start = 1'b0;
      for (int k = 0; k < nk; k++) begin
         for (int c = 0; c < nc; c++) begin
            hs_load(dly);
            chk("kgroup_idx", int'(kgroup_idx), k);
            chk("channel_idx", int'(channel_idx), c);
            hs_comp(dly);
         end
         hs_drain(dly);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_wlr"}, int'(weight_load_req), 0);
      chk({tag, "_cs"}, int'(compute_start), 0);
      chk({tag, "_ps"}, int'(ppu_start), 0);
      chk({tag, "_ld"}, int'(layer_done), 0);
      chk({tag, "_bank"}, int'(bank_sel), 0);
      chk({tag, "_kg"}, int'(kgroup_idx), 0);
      chk({tag, "_ch"}, int'(channel_idx), 0);
   endtask

   initial begin
      int cs0, ps0, ld0, bad;
      rst = 1'b1;
      start = 1'b0;
      num_kgroup = '0;
      num_channel = '0;
      weight_load_done = 1'b0;
      compute_done = 1'b0;
      PPU_finish_en = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      chk_all_zero("reset");
      chk("reset_timeout", int'(timeout), 0);

      // Nominal layer 2 x 3, responses 2 cycles after each request
      cs0 = n_cs; ps0 = n_ps; ld0 = n_ld;
      run_layer(2, 3, 2);
      chk("nom_layer_done", int'(layer_done), 1);
      chk("nom_bank", int'(bank_sel), 1);
      tick();
      chk("nom_idle", int'(busy), 0);
      chk("nom_ld_drop", int'(layer_done), 0);
      chk("nom_cs_count", n_cs - cs0, 6);
      chk("nom_ps_count", n_ps - ps0, 2);
      chk("nom_ld_count", n_ld - ld0, 1);

      // Stray handshakes, then mid-layer reset at kgroup 1 channel 2
      num_kgroup = 4'd2;
      num_channel = 4'd3;
      start = 1'b1;
      tick();
      start = 1'b0;
      compute_done = 1'b1;
      repeat (3) tick();
      chk("stray_cd_wlr", int'(weight_load_req), 1);
      chk("stray_cd_ch", int'(channel_idx), 0);
      chk("stray_cd_cs", int'(compute_start), 0);
      weight_load_done = 1'b1;
      tick();
      weight_load_done = 1'b0;
      compute_done = 1'b0;
      chk("simul_cs", int'(compute_start), 1);
      chk("simul_ch", int'(channel_idx), 0);
      PPU_finish_en = 1'b1;
      weight_load_done = 1'b1;
      repeat (3) tick();
      PPU_finish_en = 1'b0;
      weight_load_done = 1'b0;
      chk("stray_pf_wlr", int'(weight_load_req), 0);
      chk("stray_pf_ps", int'(ppu_start), 0);
      chk("stray_pf_cs", int'(compute_start), 0);
      chk("stray_pf_ch", int'(channel_idx), 0);
      chk("stray_pf_busy", int'(busy), 1);
      compute_done = 1'b1;
      tick();
      compute_done = 1'b0;
      chk("step_wlr", int'(weight_load_req), 1);
      chk("step_ch", int'(channel_idx), 1);
      hs_load(1); hs_comp(1);
      hs_load(1); hs_comp(1);
      hs_drain(1);
      hs_load(1); hs_comp(1);
      hs_load(1); hs_comp(1);
      hs_load(1);
      chk("pre_rst_cs", int'(compute_start), 1);
      chk("pre_rst_kg", int'(kgroup_idx), 1);
      chk("pre_rst_ch", int'(channel_idx), 2);
      chk("pre_rst_bank", int'(bank_sel), 1);
      rst = 1'b1;
      compute_done = 1'b1;
      tick();
      rst = 1'b0;
      compute_done = 1'b0;
      chk_all_zero("midrst");
      tick();
      chk("midrst_stay", int'(busy), 0);

      // Back-to-back 4 x 3 layers, second start right after layer_done
      ld0 = n_ld; cs0 = n_cs;
      run_layer(4, 3, 1);
      chk("b2b1_ld", int'(layer_done), 1);
      chk("b2b1_bank", int'(bank_sel), 1);
      tick();
      run_layer(4, 3, 1);
      chk("b2b2_ld", int'(layer_done), 1);
      chk("b2b2_bank", int'(bank_sel), 0);
      tick();
      chk("b2b_ld_count", n_ld - ld0, 2);
      chk("b2b_cs_count", n_cs - cs0, 24);
      chk("b2b_idle", int'(busy), 0);

      // Zero counts are ignored
      cs0 = n_cs; ps0 = n_ps; ld0 = n_ld;
      bad = 0;
      num_kgroup = 4'd2;
      num_channel = 4'd0;
      start = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (busy !== 1'b0 || weight_load_req !== 1'b0) bad++;
      end
      num_kgroup = 4'd0;
      num_channel = 4'd3;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (busy !== 1'b0 || weight_load_req !== 1'b0) bad++;
      end
      start = 1'b0;
      tick();
      chk("zero_busy_cycles", bad, 0);
      chk("zero_cs", n_cs - cs0, 0);
      chk("zero_ps", n_ps - ps0, 0);
      chk("zero_ld", n_ld - ld0, 0);
      chk("zero_bank", int'(bank_sel), 0);

`ifdef PE_SEQ_WATCHDOG_EN
      ld0 = n_ld;
      num_kgroup = 4'd1;
      num_channel = 4'd1;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("wd_entry", int'(weight_load_req), 1);
      repeat (1022) tick();
      chk("wd_early", int'(timeout), 0);
      tick();
      chk("wd_pulse", int'(timeout), 1);
      chk("wd_busy_hold", int'(busy), 1);
      tick();
      chk("wd_idle", int'(busy), 0);
      chk("wd_pulse_end", int'(timeout), 0);
      chk("wd_no_ld", n_ld - ld0, 0);
      chk("wd_bank", int'(bank_sel), 0);
`else
      chk("no_wd_timeout", n_to, 0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/pe_layer_seq.md
PE_LAYER_SEQ -- requirements
Module: pe_layer_seq

Interface
REQ-001 SHALL have parameter KP_W, default 4, width of the output-channel-group (k') count and index.
REQ-002 SHALL have parameter C_W, default 4, width of the input-channel count and index.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  layer start request; sampled only in IDLE.
REQ-006 SHALL have port num_kgroup  input  KP_W  number of k' groups for the layer (k_Conv_Boundary).
REQ-007 SHALL have port num_channel  input  C_W  number of input channels for the layer (c_Conv_Boundary).
REQ-008 SHALL have port weight_load_req  output  1  level; requests the compressed-weight stream for the current (kgroup, channel).
REQ-009 SHALL have port weight_load_done  input  1  pulse; weight stream complete.
REQ-010 SHALL have port compute_start  output  1  one-cycle pulse; starts the multiplier-array pass.
REQ-011 SHALL have port compute_done  input  1  pulse; multiplier-array pass complete.
REQ-012 SHALL have port ppu_start  output  1  one-cycle pulse; starts PPU drain of accumulators into OARAM.
REQ-013 SHALL have port PPU_finish_en  input  1  pulse; PPU drain complete.
REQ-014 SHALL have port bank_sel  output  1  OARAM ping-pong select: 0 selects OARAM_S_0 as output bank, 1 selects OARAM_S_1.
REQ-015 SHALL have ports kgroup_idx  output  KP_W  and  channel_idx  output  C_W  holding the current loop indices.
REQ-016 SHALL have ports busy  output  1  (state != IDLE) and layer_done  output  1  (one-cycle pulse at layer end).
REQ-017 SHALL have port timeout  output  1  one-cycle pulse on watchdog expiry (see Configuration).

Function
REQ-018 SHALL implement the states IDLE, LOAD_W, COMPUTE, DRAIN and SWAP, with all outputs registered.
REQ-019 IDLE: start=1 with num_kgroup!=0 and num_channel!=0 SHALL latch both counts, clear the indices and enter LOAD_W on the next edge.
REQ-020 IDLE: start=1 with either count equal to 0 SHALL be ignored; the block stays in IDLE and all outputs stay at 0.
REQ-021 weight_load_req SHALL be 1 during every cycle in LOAD_W and 0 in all other states.
REQ-022 LOAD_W: weight_load_done=1 SHALL cause entry to COMPUTE on the next edge.
REQ-023 compute_start SHALL be 1 only in the first cycle of each COMPUTE visit.
REQ-024 COMPUTE: compute_done=1 when channel_idx is below num_channel-1 SHALL increment channel_idx and return to LOAD_W.
REQ-025 COMPUTE: compute_done=1 when channel_idx equals num_channel-1 SHALL enter DRAIN.
REQ-026 ppu_start SHALL be 1 only in the first cycle of DRAIN.
REQ-027 DRAIN: PPU_finish_en=1 when kgroup_idx is below num_kgroup-1 SHALL increment kgroup_idx, clear channel_idx and enter LOAD_W.
REQ-028 DRAIN: PPU_finish_en=1 on the last k' group SHALL enter SWAP.
REQ-029 SWAP SHALL last exactly one cycle: toggle bank_sel, pulse layer_done and return to IDLE.
REQ-030 Handshake inputs that arrive in a state other than the one waiting for them SHALL be ignored; this covers compute_done in LOAD_W and weight_load_done in COMPUTE.
REQ-031 When a handshake pulse and its successor state's input are asserted in the same cycle, only the current state's input SHALL be acted on.
REQ-032 start SHALL be ignored while busy=1.
REQ-033 Changes to num_kgroup or num_channel while busy=1 SHALL have no effect; the latched values apply.
REQ-034 Latency per (kgroup, channel) step SHALL be one cycle from each input pulse to the next state; there SHALL be no added bubbles.

Reset
REQ-035 rst=1 SHALL force IDLE and set all outputs, counters, latched counts and bank_sel to 0 on the next edge, including when asserted mid-layer.
REQ-036 rst SHALL take priority over every other input in the same cycle.

Configuration
REQ-037 With macro PE_SEQ_WATCHDOG_EN defined, a 10-bit counter SHALL clear on each state entry and increment every cycle in LOAD_W, COMPUTE and DRAIN.
REQ-038 With PE_SEQ_WATCHDOG_EN defined, a counter value of 1023 SHALL pulse timeout for one cycle and force IDLE; bank_sel SHALL stay unchanged and layer_done SHALL not pulse.
REQ-039 Without PE_SEQ_WATCHDOG_EN, timeout SHALL be tied to 0, no counter SHALL exist, and the wait states SHALL wait indefinitely.

Verification
REQ-040 Nominal layer: num_kgroup=2, num_channel=3, each handshake answered 2 cycles after its request -> exactly 6 compute_start pulses, 2 ppu_start pulses, 1 layer_done pulse, and bank_sel 0->1.
REQ-041 Two back-to-back layers with num_kgroup=4, num_channel=3 -> bank_sel 0->1->0 and 2 layer_done pulses; the second start issued on the cycle after layer_done is accepted.
REQ-042 Zero count: start with num_channel=0 -> busy stays 0 for 10 cycles, no pulses, bank_sel unchanged.
REQ-043 Stray pulses: compute_done held during LOAD_W and PPU_finish_en during COMPUTE -> no state change, channel_idx unchanged.
REQ-044 Mid-layer reset: rst asserted in COMPUTE at kgroup_idx=1, channel_idx=2 -> next cycle all outputs 0, state IDLE, bank_sel 0.
REQ-045 Watchdog (PE_SEQ_WATCHDOG_EN only): weight_load_done withheld -> timeout pulses exactly 1023 cycles after LOAD_W entry, busy=0 the following cycle, and layer_done never pulses.
